// File: rtl/ov7670_stream_gen_if.sv
// OV7670 camera-side pixel bus: frame sync, line valid and one byte per pclk.
interface ov7670_stream_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output vsync, output href, output data);
  modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670-style RGB444 frame transmitter driven from internal test patterns.
// All outputs are registered and computed from the next-cycle counters/state.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  ov7670_stream_gen_if.master        cam,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt
);

  localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned COL_W       = $clog2(LINE_LEN);
  localparam int unsigned LINE_W      = $clog2(FRAME_LINES);
  localparam int unsigned PW0         = (COL_W > LINE_W) ? COL_W : LINE_W;
  localparam int unsigned PW          = (PW0 > 5) ? PW0 : 5;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0]  HREF_END  = COL_W'(2 * H_ACTIVE);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(VSYNC_LINES + V_BACK - 1);
  localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] FR_LAST   = LINE_W'(FRAME_LINES - 1);
  localparam logic [PW-1:0]     ACT_FIRST = PW'(VSYNC_LINES + V_BACK);
  localparam logic [PW-1:0]     BAR_W     = PW'(H_ACTIVE / 8);
  localparam logic [PW-1:0]     BIT4      = PW'(16);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          mode_q, mode_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic [7:0]          data_q, data_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  logic                col_wrap;
  logic [PW-1:0]       px_x, px_y, bar;
  logic                chk;
  logic [11:0]         rgb;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    line_d   = line_q;
    mode_d   = mode_q;
    col_wrap = (col_q == COL_LAST);

    if (state_q == S_IDLE) begin
      col_d  = '0;
      line_d = '0;
      if (enable) begin
        state_d = S_VSYNC;
        mode_d  = mode;
      end
    end else begin
      col_d = col_wrap ? '0 : col_q + COL_ONE;
      if (col_wrap) begin
        line_d = (line_q == FR_LAST) ? '0 : line_q + LINE_ONE;
        case (state_q)
          S_VSYNC:  if (line_q == VS_LAST)  state_d = S_VBACK;
          S_VBACK:  if (line_q == VB_LAST)  state_d = S_ACTIVE;
          S_ACTIVE: if (line_q == ACT_LAST) state_d = S_VFRONT;
          S_VFRONT: if (line_q == FR_LAST) begin
            if (enable) begin
              state_d = S_VSYNC;
              mode_d  = mode;
            end else begin
              state_d = S_IDLE;
            end
          end
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  // Pattern generation looks at the next-cycle position so data lines up with href.
  always_comb begin
    px_x = PW'(col_d) >> 1;
    px_y = PW'(line_d) - ACT_FIRST;
    bar  = px_x / BAR_W;
    chk  = |((px_x ^ px_y) & BIT4);
    rgb  = 12'h000;

    case (mode_q)
      2'b00: begin
        case (bar)
          PW'(0):  rgb = 12'hFFF;
          PW'(1):  rgb = 12'hFF0;
          PW'(2):  rgb = 12'h0FF;
          PW'(3):  rgb = 12'h0F0;
          PW'(4):  rgb = 12'hF0F;
          PW'(5):  rgb = 12'hF00;
          PW'(6):  rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'b01:   rgb = {3{px_x[3:0]}};
      2'b10:   rgb = chk ? 12'hFFF : 12'h000;
      default: rgb = {frame_cnt_q[3:0], ~frame_cnt_q[3:0], 4'h0};
    endcase

    vsync_d      = (state_d == S_VSYNC);
    href_d       = (state_d == S_ACTIVE) && (col_d < HREF_END);
    data_d       = '0;
    if (href_d) begin
      data_d = col_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    end
    frame_done_d = (state_d == S_VFRONT) && (line_d == FR_LAST) && (col_d == COL_LAST);
    frame_cnt_d  = frame_done_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      mode_q       <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      mode_q       <= mode_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign cam.vsync  = vsync_q;
  assign cam.href   = href_q;
  assign cam.data   = data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
